// File: rtl/scancode_decoder.sv
// PS/2 set-2 scancode decoder: prefix parser, modifier tracking, layout ROM lookup
// and a first-word-fall-through character FIFO.
module scancode_decoder #(
    parameter int LAYOUT_BITS = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic [LAYOUT_BITS-1:0] layout_sel,
    input  logic                   char_ready,
    output logic [7:0]             char_data,
    output logic                   char_valid,
    output logic                   shift_state,
    output logic                   caps_state,
    output logic                   overflow,
    output logic [CNT_W-1:0]       fifo_count
);

    localparam int ADDR_W = LAYOUT_BITS + 9;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_shiftL;
    logic              r_shiftR;
    logic              r_caps;
    logic              w_setL;
    logic              w_setR;
    logic              w_clrL;
    logic              w_clrR;
    logic              w_toggleCaps;
    logic              w_makeReq;
    logic              r_lookupValid;
    logic [ADDR_W-1:0] r_lookupAddr;
    logic [7:0]        w_romData;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              w_push;
    logic              w_pop;
    logic              w_write;
    logic              w_empty;
    logic              w_full;

    // Layout table: address is {layout, shifted plane, scancode}. 0xFF = no char, 0x00 = modifier.
    function automatic logic [7:0] romEntry(input logic [ADDR_W-1:0] addr);
        logic [LAYOUT_BITS-1:0] layout;
        logic [8:0]             key;
        layout   = addr[ADDR_W-1:9];
        key      = addr[8:0];
        romEntry = 8'hFF;
        if (layout == '0) begin
            case (key)
                9'h01C: romEntry = 8'h61;
                9'h016: romEntry = 8'h31;
                9'h05A: romEntry = 8'h7E;
                9'h029: romEntry = 8'h7D;
                9'h032: romEntry = 8'h62;
                9'h021: romEntry = 8'h63;
                9'h11C: romEntry = 8'h41;
                9'h15A: romEntry = 8'h7E;
                9'h129: romEntry = 8'h7D;
                9'h132: romEntry = 8'h42;
                9'h121: romEntry = 8'h43;
                9'h011, 9'h014, 9'h111, 9'h114: romEntry = 8'h00;
                default: romEntry = 8'hFF;
            endcase
        end else if (layout == LAYOUT_BITS'(1)) begin
            case (key)
                9'h015: romEntry = 8'h61;
                9'h01C: romEntry = 8'h71;
                9'h016: romEntry = 8'h26;
                9'h115: romEntry = 8'h41;
                9'h11C: romEntry = 8'h51;
                9'h116: romEntry = 8'h31;
                9'h011, 9'h014, 9'h111, 9'h114: romEntry = 8'h00;
                default: romEntry = 8'hFF;
            endcase
        end
    endfunction

    always_comb begin
        w_nextState  = r_state;
        w_setL       = 1'b0;
        w_setR       = 1'b0;
        w_clrL       = 1'b0;
        w_clrR       = 1'b0;
        w_toggleCaps = 1'b0;
        w_makeReq    = 1'b0;
        if (rx_valid) begin
            w_nextState = ST_IDLE;
            case (r_state)
                ST_IDLE: begin
                    case (rx_data)
                        8'hF0:   w_nextState  = ST_BRK;
                        8'hE0:   w_nextState  = ST_EXT;
                        8'h12:   w_setL       = 1'b1;
                        8'h59:   w_setR       = 1'b1;
                        8'h58:   w_toggleCaps = 1'b1;
                        default: w_makeReq    = 1'b1;
                    endcase
                end
                ST_BRK: begin
                    w_clrL = (rx_data == 8'h12);
                    w_clrR = (rx_data == 8'h59);
                end
                ST_EXT: begin
                    if (rx_data == 8'hF0) begin
                        w_nextState = ST_EXT_BRK;
                    end
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_shiftL      <= 1'b0;
            r_shiftR      <= 1'b0;
            r_caps        <= 1'b0;
            r_lookupValid <= 1'b0;
            r_lookupAddr  <= '0;
        end else begin
            r_state       <= w_nextState;
            r_shiftL      <= (r_shiftL | w_setL) & ~w_clrL;
            r_shiftR      <= (r_shiftR | w_setR) & ~w_clrR;
            r_caps        <= r_caps ^ w_toggleCaps;
            r_lookupValid <= w_makeReq;
            if (w_makeReq) begin
                r_lookupAddr <= {layout_sel, (r_shiftL | r_shiftR) ^ r_caps, rx_data};
            end
        end
    end

    assign w_romData = romEntry(r_lookupAddr);
    assign w_push    = r_lookupValid && (w_romData != 8'hFF) && (w_romData != 8'h00);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = !w_empty && char_ready;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign w_write   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= w_romData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_write) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign char_valid  = !w_empty;
    assign char_data   = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign shift_state = r_shiftL | r_shiftR;
    assign caps_state  = r_caps;

endmodule

// File: tb/tb_scancode_decoder.sv
// Self-checking bench for scancode_decoder: directed scenarios plus a randomized run
// compared cycle by cycle against a queue-based keyboard model.
module tb_scancode_decoder;

    localparam int LB    = 1;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [LB-1:0] layout_sel;
    logic          char_ready;
    logic [7:0]    char_data;
    logic          char_valid;
    logic          shift_state;
    logic          caps_state;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;

    // Keyboard model: held keys, pending prefixes, character queue, one-cycle lookup delay.
    logic [7:0] refRom [int];
    logic [7:0] mQ [$];
    bit         mLeft, mRight, mCaps, mBrk, mExt, mOvf, mPipeValid;
    logic [7:0] mPipeChar;

    scancode_decoder #(.LAYOUT_BITS(LB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .layout_sel(layout_sel), .char_ready(char_ready), .char_data(char_data),
        .char_valid(char_valid), .shift_state(shift_state), .caps_state(caps_state),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic initTable();
        refRom[0*512 + 0*256 + 'h1C] = 8'h61;
        refRom[0*512 + 0*256 + 'h16] = 8'h31;
        refRom[0*512 + 0*256 + 'h5A] = 8'h7E;
        refRom[0*512 + 0*256 + 'h29] = 8'h7D;
        refRom[0*512 + 0*256 + 'h32] = 8'h62;
        refRom[0*512 + 0*256 + 'h21] = 8'h63;
        refRom[0*512 + 1*256 + 'h1C] = 8'h41;
        refRom[0*512 + 1*256 + 'h5A] = 8'h7E;
        refRom[0*512 + 1*256 + 'h29] = 8'h7D;
        refRom[0*512 + 1*256 + 'h32] = 8'h42;
        refRom[0*512 + 1*256 + 'h21] = 8'h43;
        refRom[1*512 + 0*256 + 'h15] = 8'h61;
        refRom[1*512 + 0*256 + 'h1C] = 8'h71;
        refRom[1*512 + 0*256 + 'h16] = 8'h26;
        refRom[1*512 + 1*256 + 'h15] = 8'h41;
        refRom[1*512 + 1*256 + 'h1C] = 8'h51;
        refRom[1*512 + 1*256 + 'h16] = 8'h31;
        for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < 2; s++) begin
                refRom[l*512 + s*256 + 'h11] = 8'h00;
                refRom[l*512 + s*256 + 'h14] = 8'h00;
            end
        end
    endtask

    function automatic logic [7:0] refLookup(input int l, input bit sh, input logic [7:0] code);
        int key;
        key = l*512 + (sh ? 256 : 0) + int'(code);
        return refRom.exists(key) ? refRom[key] : 8'hFF;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mLeft = 0; mRight = 0; mCaps = 0; mBrk = 0; mExt = 0; mOvf = 0;
        mPipeValid = 0; mPipeChar = 8'h00;
    endtask

    task automatic modelClock(input bit v, input logic [7:0] d, input int l, input bit r);
        int         sz;
        bit         pop;
        logic [7:0] ch;
        sz  = mQ.size();
        pop = (sz > 0) && r;
        if (pop) void'(mQ.pop_front());
        if (mPipeValid) begin
            if (sz < DEPTH || pop) mQ.push_back(mPipeChar);
            else mOvf = 1;
        end
        mPipeValid = 0;
        if (v) begin
            if (mExt) begin
                if (!mBrk && d == 8'hF0) mBrk = 1;
                else begin mExt = 0; mBrk = 0; end
            end else if (mBrk) begin
                if (d == 8'h12) mLeft = 0;
                if (d == 8'h59) mRight = 0;
                mBrk = 0;
            end else begin
                case (d)
                    8'hF0: mBrk = 1;
                    8'hE0: mExt = 1;
                    8'h12: mLeft = 1;
                    8'h59: mRight = 1;
                    8'h58: mCaps = !mCaps;
                    default: begin
                        ch = refLookup(l, (mLeft || mRight) ^ mCaps, d);
                        if (ch != 8'hFF && ch != 8'h00) begin
                            mPipeValid = 1;
                            mPipeChar  = ch;
                        end
                    end
                endcase
            end
        end
    endtask

    function automatic logic [14:0] modelOut();
        logic [7:0] head;
        head = (mQ.size() > 0) ? mQ[0] : 8'h00;
        return {mQ.size() > 0, head, CW'(mQ.size()), mLeft || mRight, mCaps, mOvf};
    endfunction

    // Drive one cycle's inputs, clock it, advance the model, and leave time 1 after the edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l, input bit r);
        rx_valid   = v;
        rx_data    = d;
        layout_sel = l;
        char_ready = r;
        @(posedge clk);
        modelClock(v, d, int'(l), r);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_valid = 0; rx_data = 0; layout_sel = 0; char_ready = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({char_valid, char_data, fifo_count, shift_state, caps_state, overflow} !== 15'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%0b d=%h cnt=%0d sh=%0b caps=%0b ovf=%0b want all zero",
                     char_valid, char_data, fifo_count, shift_state, caps_state, overflow);
        end
        reset_n = 1'b1;
        applyStimulus(0, 8'h00, 0, 1);
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got char_valid=%0b want 0", char_valid);
        end
    endtask

    task automatic test_basic_make_break();
        applyStimulus(1, 8'h1C, 0, 1);
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL make_latency_early: got char_valid=%0b want 0", char_valid);
        end
        applyStimulus(1, 8'hF0, 0, 1);
        checks++;
        if ({char_valid, char_data} !== {1'b1, 8'h61}) begin
            errors++;
            $display("[TB] FAIL make_char: got v=%0b d=%h want v=1 d=61", char_valid, char_data);
        end
        applyStimulus(1, 8'h1C, 0, 1);
        checks++;
        if ({char_valid, fifo_count} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL make_one_cycle: got v=%0b cnt=%0d want v=0 cnt=0", char_valid, fifo_count);
        end
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_no_char: got char_valid=%0b want 0", char_valid);
        end
    endtask

    task automatic test_shift();
        logic [7:0] got [$];
        logic [7:0] seq [5] = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C};
        bit         wantShift [5] = '{1, 1, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, seq[i], 0, 1);
            if (char_valid) got.push_back(char_data);
            checks++;
            if (shift_state !== wantShift[i]) begin
                errors++;
                $display("[TB] FAIL shift_state_%0d: got %0b want %0b", i, shift_state, wantShift[i]);
            end
        end
        repeat (2) begin
            applyStimulus(0, 8'h00, 0, 1);
            if (char_valid) got.push_back(char_data);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 8'h41 || got[1] !== 8'h61) begin
            errors++;
            $display("[TB] FAIL shift_chars: got %0d chars %p want 41 61", got.size(), got);
        end
    endtask

    task automatic test_caps_ext();
        logic [7:0] got [$];
        logic [7:0] capsSeq [4] = '{8'h58, 8'h1C, 8'h58, 8'h1C};
        logic [7:0] extSeq [5]  = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, capsSeq[i], 0, 1);
            if (char_valid) got.push_back(char_data);
            if (i == 1) begin
                checks++;
                if (caps_state !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL caps_on: got %0b want 1", caps_state);
                end
            end
        end
        repeat (2) begin
            applyStimulus(0, 8'h00, 0, 1);
            if (char_valid) got.push_back(char_data);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 8'h41 || got[1] !== 8'h61 || caps_state !== 1'b0) begin
            errors++;
            $display("[TB] FAIL caps_chars: got %0d chars %p caps=%0b want 41 61 caps=0", got.size(), got, caps_state);
        end
        got.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, extSeq[i], 0, 1);
            if (char_valid) got.push_back(char_data);
        end
        applyStimulus(1, 8'h1C, 0, 1);
        if (char_valid) got.push_back(char_data);
        repeat (2) begin
            applyStimulus(0, 8'h00, 0, 1);
            if (char_valid) got.push_back(char_data);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 8'h61) begin
            errors++;
            $display("[TB] FAIL ext_discard: got %0d chars %p want only 61", got.size(), got);
        end
    endtask

    task automatic test_overflow();
        int drained;
        repeat (4) applyStimulus(1, 8'h1C, 0, 0);
        repeat (2) applyStimulus(0, 8'h00, 0, 0);
        checks++;
        if ({fifo_count, overflow, char_valid, char_data} !== {CW'(4), 1'b0, 1'b1, 8'h61}) begin
            errors++;
            $display("[TB] FAIL fifo_full: got cnt=%0d ovf=%0b v=%0b d=%h want cnt=4 ovf=0 v=1 d=61",
                     fifo_count, overflow, char_valid, char_data);
        end
        applyStimulus(1, 8'h1C, 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        checks++;
        if ({fifo_count, overflow} !== {CW'(4), 1'b0}) begin
            errors++;
            $display("[TB] FAIL full_push_pop: got cnt=%0d ovf=%0b want cnt=4 ovf=0", fifo_count, overflow);
        end
        repeat (2) applyStimulus(1, 8'h1C, 0, 0);
        repeat (2) applyStimulus(0, 8'h00, 0, 0);
        checks++;
        if ({fifo_count, overflow} !== {CW'(4), 1'b1}) begin
            errors++;
            $display("[TB] FAIL overflow_set: got cnt=%0d ovf=%0b want cnt=4 ovf=1", fifo_count, overflow);
        end
        drained = 0;
        repeat (6) begin
            if (char_valid && char_data === 8'h61) drained++;
            applyStimulus(0, 8'h00, 0, 1);
        end
        checks++;
        if (drained != 4 || fifo_count !== CW'(0) || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain: got %0d chars cnt=%0d ovf=%0b want 4 chars cnt=0 ovf=1",
                     drained, fifo_count, overflow);
        end
        applyStimulus(1, 8'h12, 0, 1);
        applyStimulus(1, 8'h16, 0, 1);
        repeat (2) applyStimulus(0, 8'h00, 0, 1);
        checks++;
        if ({char_valid, fifo_count} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL shifted_ff_drop: got v=%0b cnt=%0d want v=0 cnt=0", char_valid, fifo_count);
        end
        applyStimulus(1, 8'hF0, 0, 1);
        applyStimulus(1, 8'h12, 0, 1);
    endtask

    task automatic test_reset_midstream();
        logic [7:0] mk [3] = '{8'h1C, 8'h16, 8'h1C};
        for (int i = 0; i < 3; i++) applyStimulus(1, mk[i], 0, 0);
        repeat (2) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'h58, 0, 0);
        applyStimulus(1, 8'hF0, 0, 0);
        checks++;
        if ({fifo_count, caps_state} !== {CW'(3), 1'b1}) begin
            errors++;
            $display("[TB] FAIL pre_reset_queue: got cnt=%0d caps=%0b want cnt=3 caps=1", fifo_count, caps_state);
        end
        reset_n = 1'b0;
        modelReset();
        #2;
        checks++;
        if ({char_valid, char_data, fifo_count, shift_state, caps_state, overflow} !== 15'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%0b d=%h cnt=%0d sh=%0b caps=%0b ovf=%0b want all zero",
                     char_valid, char_data, fifo_count, shift_state, caps_state, overflow);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1, 8'h1C, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checks++;
        if ({char_valid, char_data} !== {1'b1, 8'h61}) begin
            errors++;
            $display("[TB] FAIL make_after_reset: got v=%0b d=%h want v=1 d=61", char_valid, char_data);
        end
        applyStimulus(1, 8'h1C, 0, 1);
        reset_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) applyStimulus(0, 8'h00, 0, 1);
        checks++;
        if ({char_valid, fifo_count} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL pending_lookup_reset: got v=%0b cnt=%0d want v=0 cnt=0", char_valid, fifo_count);
        end
    endtask

    task automatic test_random();
        logic [7:0]  pool [16] = '{8'h1C, 8'h16, 8'h5A, 8'h29, 8'h32, 8'h21, 8'h15, 8'h12,
                                   8'h59, 8'h58, 8'hF0, 8'hE0, 8'h11, 8'h14, 8'h75, 8'h1C};
        logic [14:0] want;
        logic [14:0] got;
        bit          v;
        logic [7:0]  d;
        for (int c = 0; c < 600; c++) begin
            v = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 15) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
            applyStimulus(v, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            want = modelOut();
            got  = {char_valid, char_data, fifo_count, shift_state, caps_state, overflow};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL random_cycle_%0d: got v=%0b d=%h cnt=%0d sh=%0b caps=%0b ovf=%0b want v=%0b d=%h cnt=%0d sh=%0b caps=%0b ovf=%0b",
                         c, got[14], got[13:6], got[5:3], got[2], got[1], got[0],
                         want[14], want[13:6], want[5:3], want[2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        initTable();
        test_reset();
        test_basic_make_break();
        test_shift();
        test_caps_ext();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
